placement_eval: RTL and testbench
=================================

Name: placement_eval

Overview:
- Stand-alone wirelength evaluation stage that runs directly downstream of the placement engine.
- After placement finishes, it walks the edge list and fetches both endpoint positions from the pos_X/pos_Y RAMs.
- For each edge it accumulates the Manhattan cost and the 1-hop cost, then reports the totals with a start/done handshake.
- Pulling evaluation out of the placer lets the placer's FSM finish earlier and lets one evaluator score placements from several placer variants.

Parameters:
- N_EDGE, 30, number of edges to evaluate (edge addresses 0..N_EDGE-1).
- W, 32, datapath width of positions, node ids and accumulators (signed).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins an evaluation when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when results are final
- re_edge  out  1  read enable to both edge ROMs (EA, EB)
- addr_edge  out  W  edge index
- edge_a  in  W  node id from EA ROM
- edge_b  in  W  node id from EB ROM
- re_pos  out  1  read enable to pos_X and pos_Y RAMs
- addr_pos  out  W  node id
- pos_x  in  W  signed X position
- pos_y  in  W  signed Y position
- sum  out  W  signed total of (dx+dy-1)
- sum_1hop  out  W  signed total of (ceil(dx/2)+ceil(dy/2)-1)
- unplaced  out  W  count of edges with an endpoint at -1
- cycles  out  W  clock count from start acceptance to done

Behaviour:
- Reset (synchronous, active-high): all outputs 0; FSM to IDLE; re_* 0; addr_* 0. Reset mid-evaluation aborts immediately with no done pulse.
- Memory timing: re/addr are registered outputs. The memory samples them one edge later and data are sampled in the state after a single WAIT state, matching the existing ROM/RAM models.
- FSM states and transitions:
  - IDLE: on start, clear sum, sum_1hop, unplaced and cycles; set i=0; go to RD_E. A start arriving while busy is ignored.
  - RD_E: if i==N_EDGE, go to DONE. Otherwise re_edge=1, addr_edge=i, go to WAIT_E.
  - WAIT_E: go to RD_A.
  - RD_A: latch edge_a and edge_b into na and nb; re_pos=1, addr_pos=edge_a; go to WAIT_A.
  - WAIT_A: go to LAT_A.
  - LAT_A: xa=pos_x, ya=pos_y; re_pos=1, addr_pos=nb; go to WAIT_B.
  - WAIT_B: go to LAT_B.
  - LAT_B: xb=pos_x, yb=pos_y; go to CALC.
  - CALC: if any of xa, ya, xb, yb equals -1, unplaced++, i++, go to RD_E. Otherwise dx=|xa-xb| and dy=|ya-yb| (two's complement negate), go to ACC.
  - ACC: sum += dx+dy-1; sum_1hop += (dx>>1)+dx[0]+(dy>>1)+dy[0]-1; i++; go to RD_E.
  - DONE: done=1 for one cycle; busy=0; outputs hold until the next accepted start; go to IDLE.
- Per-edge latency: 9 cycles placed, 8 unplaced. Total for N_EDGE all-placed edges: 9*N_EDGE + 2 cycles from the start edge to done.
- cycles increments every cycle while busy, including the DONE cycle.
- Arithmetic: accumulators wrap modulo 2^W with no saturation. Coincident endpoints (dx=dy=0) contribute -1 to both sums, which is intentional and matches the placer's cost model.
- N_EDGE=0: done pulses 2 cycles after start; all results 0.

Optional Feature:
- Macro: PLACE_EVAL_HIST_EN.
- When defined:
  - Adds output port hist_max (W): the largest dx+dy seen.
  - Adds an 8-entry internal histogram of dx+dy, with bin = min(dx+dy, 7).
  - After DONE the block $write's the histogram in the same cycle, before done rises.
  - Both hist_max and the histogram are cleared on start.
- When undefined: no extra port and no histogram logic; all other timing identical.

Test Plan:
- Single edge, A at (0,0), B at (3,2), N_EDGE=1: start -> sum=4, sum_1hop=2, unplaced=0, done at cycle 11 after start.
- Adjacent nodes at (2,2) and (2,3) -> sum=0, sum_1hop=0. Coincident nodes at (1,1) and (1,1) -> sum=-1, sum_1hop=-1.
- Negative difference, A at (5,0), B at (0,4) -> dx=5, dy=4, sum=8, sum_1hop=3+2-1=4.
- 3 edges where edge 1 has B at (-1,-1) -> unplaced=1; sum covers only edges 0 and 2; total cycles 9+8+9+2=28.
- Assert reset during WAIT_A of edge 2 -> all outputs 0 next cycle, no done; a new start re-runs from edge 0 with correct totals.
- Start pulse while busy is ignored (one done only). With PLACE_EVAL_HIST_EN and distances {5,4,9} -> hist_max=9, bin7=1, bin5=1, bin4=1.

Source files
------------

// File: rtl/placement_eval.sv
// Wirelength evaluator: walks the edge ROMs, fetches both endpoint positions and
// accumulates Manhattan and 1-hop costs. Optional histogram/hist_max under PLACE_EVAL_HIST_EN.
module placement_eval #(
    parameter int N_EDGE = 30,
    parameter int W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                re_edge,
    output logic [W-1:0]        addr_edge,
    input  logic [W-1:0]        edge_a,
    input  logic [W-1:0]        edge_b,
    output logic                re_pos,
    output logic [W-1:0]        addr_pos,
    input  logic signed [W-1:0] pos_x,
    input  logic signed [W-1:0] pos_y,
    output logic signed [W-1:0] sum,
    output logic signed [W-1:0] sum_1hop,
    output logic [W-1:0]        unplaced,
    output logic [W-1:0]        cycles
`ifdef PLACE_EVAL_HIST_EN
    ,
    output logic [W-1:0]        hist_max
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_E, S_WAIT_E, S_RD_A, S_WAIT_A, S_LAT_A,
        S_WAIT_B, S_LAT_B, S_CALC, S_ACC, S_DONE
    } state_t;

    localparam logic [W-1:0] ZERO     = {W{1'b0}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] NEG1     = {W{1'b1}};
    localparam logic [W-1:0] N_EDGE_W = W'(N_EDGE);

    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a - b;
        abs_diff = d[W-1] ? (~d + ONE) : d;
    endfunction

    function automatic logic [W-1:0] ceil_half(input logic [W-1:0] v);
        ceil_half = (v >> 1) + {{(W-1){1'b0}}, v[0]};
    endfunction

    state_t       state_q, state_d;
    logic [W-1:0] i_q, i_d, nb_q, nb_d;
    logic [W-1:0] xa_q, xa_d, ya_q, ya_d, xb_q, xb_d, yb_q, yb_d;
    logic [W-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [W-1:0] sum_q, sum_d, sum_1hop_q, sum_1hop_d, unplaced_q, unplaced_d, cycles_q, cycles_d;
    logic [W-1:0] addr_edge_q, addr_edge_d, addr_pos_q, addr_pos_d;
    logic         busy_q, busy_d, done_q, done_d, re_edge_q, re_edge_d, re_pos_q, re_pos_d;

    // Next-state and datapath for the evaluation sequencer.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        nb_d        = nb_q;
        xa_d        = xa_q;
        ya_d        = ya_q;
        xb_d        = xb_q;
        yb_d        = yb_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        sum_d       = sum_q;
        sum_1hop_d  = sum_1hop_q;
        unplaced_d  = unplaced_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        re_edge_d   = 1'b0;
        addr_edge_d = addr_edge_q;
        re_pos_d    = 1'b0;
        addr_pos_d  = addr_pos_q;
        cycles_d    = (state_q != S_IDLE) ? cycles_q + ONE : cycles_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sum_d      = ZERO;
                    sum_1hop_d = ZERO;
                    unplaced_d = ZERO;
                    cycles_d   = ZERO;
                    i_d        = ZERO;
                    busy_d     = 1'b1;
                    state_d    = S_RD_E;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_RD_E: begin
                if (i_q == N_EDGE_W) begin
                    state_d     = S_DONE;
                end else begin
                    re_edge_d   = 1'b1;
                    addr_edge_d = i_q;
                    state_d     = S_WAIT_E;
                end
            end
            S_WAIT_E: state_d = S_RD_A;
            S_RD_A: begin
                nb_d       = edge_b;
                re_pos_d   = 1'b1;
                addr_pos_d = edge_a;
                state_d    = S_WAIT_A;
            end
            S_WAIT_A: state_d = S_LAT_A;
            S_LAT_A: begin
                xa_d       = pos_x;
                ya_d       = pos_y;
                re_pos_d   = 1'b1;
                addr_pos_d = nb_q;
                state_d    = S_WAIT_B;
            end
            S_WAIT_B: state_d = S_LAT_B;
            S_LAT_B: begin
                xb_d    = pos_x;
                yb_d    = pos_y;
                state_d = S_CALC;
            end
            S_CALC: begin
                // -1 in any coordinate marks a node the placer never placed
                if ((xa_q == NEG1) || (ya_q == NEG1) || (xb_q == NEG1) || (yb_q == NEG1)) begin
                    unplaced_d = unplaced_q + ONE;
                    i_d        = i_q + ONE;
                    state_d    = S_RD_E;
                end else begin
                    dx_d       = abs_diff(xa_q, xb_q);
                    dy_d       = abs_diff(ya_q, yb_q);
                    state_d    = S_ACC;
                end
            end
            S_ACC: begin
                sum_d      = sum_q + dx_q + dy_q - ONE;
                sum_1hop_d = sum_1hop_q + ceil_half(dx_q) + ceil_half(dy_q) - ONE;
                i_d        = i_q + ONE;
                state_d    = S_RD_E;
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            i_q         <= ZERO;
            nb_q        <= ZERO;
            xa_q        <= ZERO;
            ya_q        <= ZERO;
            xb_q        <= ZERO;
            yb_q        <= ZERO;
            dx_q        <= ZERO;
            dy_q        <= ZERO;
            sum_q       <= ZERO;
            sum_1hop_q  <= ZERO;
            unplaced_q  <= ZERO;
            cycles_q    <= ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            re_edge_q   <= 1'b0;
            addr_edge_q <= ZERO;
            re_pos_q    <= 1'b0;
            addr_pos_q  <= ZERO;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            nb_q        <= nb_d;
            xa_q        <= xa_d;
            ya_q        <= ya_d;
            xb_q        <= xb_d;
            yb_q        <= yb_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            sum_q       <= sum_d;
            sum_1hop_q  <= sum_1hop_d;
            unplaced_q  <= unplaced_d;
            cycles_q    <= cycles_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            re_edge_q   <= re_edge_d;
            addr_edge_q <= addr_edge_d;
            re_pos_q    <= re_pos_d;
            addr_pos_q  <= addr_pos_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign re_edge   = re_edge_q;
    assign addr_edge = addr_edge_q;
    assign re_pos    = re_pos_q;
    assign addr_pos  = addr_pos_q;
    assign sum       = sum_q;
    assign sum_1hop  = sum_1hop_q;
    assign unplaced  = unplaced_q;
    assign cycles    = cycles_q;

`ifdef PLACE_EVAL_HIST_EN
    logic [W-1:0] hist_q [8];
    logic [W-1:0] hist_d [8];
    logic [W-1:0] hist_max_q, hist_max_d, dist_s;
    logic [2:0]   bin_s;

    // Histogram of per-edge distance, bins saturating at 7.
    always_comb begin
        hist_d     = hist_q;
        hist_max_d = hist_max_q;
        dist_s     = dx_q + dy_q;
        bin_s      = (dist_s > {{(W-3){1'b0}}, 3'd7}) ? 3'd7 : dist_s[2:0];
        if ((state_q == S_IDLE) && start) begin
            for (int b = 0; b < 8; b++) begin
                hist_d[b] = ZERO;
            end
            hist_max_d = ZERO;
        end else if (state_q == S_ACC) begin
            hist_d[bin_s] = hist_q[bin_s] + ONE;
            hist_max_d    = (dist_s > hist_max_q) ? dist_s : hist_max_q;
        end else begin
            hist_max_d = hist_max_q;
        end
    end

    // Histogram registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 8; b++) begin
                hist_q[b] <= ZERO;
            end
            hist_max_q <= ZERO;
        end else begin
            hist_q     <= hist_d;
            hist_max_q <= hist_max_d;
        end
    end

    assign hist_max = hist_max_q;

`ifndef SYNTHESIS
    // Report the final histogram in the DONE cycle.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_DONE)) begin
            $write("hist: %0d %0d %0d %0d %0d %0d %0d %0d\n", hist_q[0], hist_q[1], hist_q[2],
                   hist_q[3], hist_q[4], hist_q[5], hist_q[6], hist_q[7]);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_placement_eval.sv
// Directed, table-driven bench for placement_eval with N_EDGE=3, 1 and 0 instances
// sharing one edge ROM / position RAM image.
module tb_placement_eval;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_w     [3];
    logic        busy_w      [3];
    logic        done_w      [3];
    logic        re_edge_w   [3];
    logic [31:0] addr_edge_w [3];
    logic [31:0] edge_a_w    [3];
    logic [31:0] edge_b_w    [3];
    logic        re_pos_w    [3];
    logic [31:0] addr_pos_w  [3];
    logic [31:0] pos_x_w     [3];
    logic [31:0] pos_y_w     [3];
    logic [31:0] sum_w       [3];
    logic [31:0] sum_1hop_w  [3];
    logic [31:0] unplaced_w  [3];
    logic [31:0] cycles_w    [3];
`ifdef PLACE_EVAL_HIST_EN
    logic [31:0] hist_max_w  [3];
`endif

    logic [31:0] ea_mem [8];
    logic [31:0] eb_mem [8];
    logic [31:0] px_mem [8];
    logic [31:0] py_mem [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    placement_eval #(.N_EDGE(3), .W(32)) u_dut3 (
        .clk(clk), .reset(reset), .start(start_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .re_edge(re_edge_w[0]), .addr_edge(addr_edge_w[0]), .edge_a(edge_a_w[0]), .edge_b(edge_b_w[0]),
        .re_pos(re_pos_w[0]), .addr_pos(addr_pos_w[0]), .pos_x(pos_x_w[0]), .pos_y(pos_y_w[0]),
        .sum(sum_w[0]), .sum_1hop(sum_1hop_w[0]), .unplaced(unplaced_w[0]), .cycles(cycles_w[0])
`ifdef PLACE_EVAL_HIST_EN
        , .hist_max(hist_max_w[0])
`endif
    );

    placement_eval #(.N_EDGE(1), .W(32)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .re_edge(re_edge_w[1]), .addr_edge(addr_edge_w[1]), .edge_a(edge_a_w[1]), .edge_b(edge_b_w[1]),
        .re_pos(re_pos_w[1]), .addr_pos(addr_pos_w[1]), .pos_x(pos_x_w[1]), .pos_y(pos_y_w[1]),
        .sum(sum_w[1]), .sum_1hop(sum_1hop_w[1]), .unplaced(unplaced_w[1]), .cycles(cycles_w[1])
`ifdef PLACE_EVAL_HIST_EN
        , .hist_max(hist_max_w[1])
`endif
    );

    placement_eval #(.N_EDGE(0), .W(32)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .re_edge(re_edge_w[2]), .addr_edge(addr_edge_w[2]), .edge_a(edge_a_w[2]), .edge_b(edge_b_w[2]),
        .re_pos(re_pos_w[2]), .addr_pos(addr_pos_w[2]), .pos_x(pos_x_w[2]), .pos_y(pos_y_w[2]),
        .sum(sum_w[2]), .sum_1hop(sum_1hop_w[2]), .unplaced(unplaced_w[2]), .cycles(cycles_w[2])
`ifdef PLACE_EVAL_HIST_EN
        , .hist_max(hist_max_w[2])
`endif
    );

    // Synchronous-read ROM/RAM models: data appear the edge after re/addr are sampled.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (re_edge_w[d]) begin
                edge_a_w[d] <= ea_mem[addr_edge_w[d][2:0]];
                edge_b_w[d] <= eb_mem[addr_edge_w[d][2:0]];
            end
            if (re_pos_w[d]) begin
                pos_x_w[d] <= px_mem[addr_pos_w[d][2:0]];
                pos_y_w[d] <= py_mem[addr_pos_w[d][2:0]];
            end
        end
    end

    typedef struct {
        int p [12];   // per edge: ax, ay, bx, by
        int s;
        int h;
        int u;
        int lat;
        int hm;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic load_vec(input int v);
        for (int k = 0; k < 3; k++) begin
            px_mem[2*k]   = vecs[v].p[4*k];
            py_mem[2*k]   = vecs[v].p[4*k+1];
            px_mem[2*k+1] = vecs[v].p[4*k+2];
            py_mem[2*k+1] = vecs[v].p[4*k+3];
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the cycle following done.
    task automatic run_eval(input int d, input int lat, input int es, input int eh, input int eu,
                            input string tag);
        int n;
        start_w[d] = 1'b1;
        @(posedge clk);
        #1;
        start_w[d] = 1'b0;
        check({tag, "_busy"}, {31'd0, busy_w[d]}, 32'd1);
        n = 0;
        while (!done_w[d] && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_sum"}, sum_w[d], es);
        check({tag, "_sum_1hop"}, sum_1hop_w[d], eh);
        check({tag, "_unplaced"}, unplaced_w[d], eu);
        check({tag, "_cycles"}, cycles_w[d], lat);
        check({tag, "_busy_at_done"}, {31'd0, busy_w[d]}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, {31'd0, done_w[d]}, 32'd0);
    endtask

    initial begin
        int n_done;
        for (int d = 0; d < 3; d++) begin
            start_w[d] = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            ea_mem[k] = 2 * k;
            eb_mem[k] = 2 * k + 1;
            px_mem[k] = 0;
            py_mem[k] = 0;
        end

        vecs[0] = '{'{0,0,3,2, 2,2,2,3, 1,1,1,1}, 3, 1, 0, 29, 5};
        vecs[1] = '{'{5,0,0,4, 0,0,-1,-1, 0,0,3,2}, 12, 6, 1, 28, 9};
        vecs[2] = '{'{-3,-5,4,2, 10,0,0,-10, -1,5,2,2}, 32, 16, 1, 28, 20};
        vecs[3] = '{'{-1,0,0,0, 0,-1,0,0, 0,0,0,-1}, 0, 0, 3, 26, 0};
        vecs[4] = '{'{1000000000,0,0,1000000000, 1000000000,0,0,1000000000,
                      1000000000,0,0,1000000000}, 1705032701, -1294967299, 0, 29, 2000000000};
        vecs[5] = '{'{0,0,1,1, 0,0,7,0, 3,3,0,0}, 12, 7, 0, 29, 7};
        vecs[6] = '{'{0,0,3,2, 0,0,2,2, 0,0,5,4}, 15, 7, 0, 29, 9};

        repeat (3) @(posedge clk);
        #1;
        check("rst_sum", sum_w[0], 32'd0);
        check("rst_sum_1hop", sum_1hop_w[0], 32'd0);
        check("rst_unplaced", unplaced_w[0], 32'd0);
        check("rst_cycles", cycles_w[0], 32'd0);
        check("rst_busy_done", {30'd0, busy_w[0], done_w[0]}, 32'd0);
        check("rst_re", {30'd0, re_edge_w[0], re_pos_w[0]}, 32'd0);
        check("rst_addr", addr_edge_w[0] | addr_pos_w[0], 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            load_vec(v);
            run_eval(0, vecs[v].lat, vecs[v].s, vecs[v].h, vecs[v].u, $sformatf("vec%0d", v));
`ifdef PLACE_EVAL_HIST_EN
            check($sformatf("vec%0d_hist_max", v), hist_max_w[0], vecs[v].hm);
`endif
        end

        // Single edge (0,0)-(3,2): done 11 cycles after start.
        load_vec(0);
        run_eval(1, 11, 4, 2, 0, "n1");
        // No edges: done 2 cycles after start, all zero.
        run_eval(2, 2, 0, 0, 0, "n0");

        // Reset while in WAIT_A of edge 2 aborts without done.
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        check("abort_pre_re_pos", {31'd0, re_pos_w[0]}, 32'd1);
        check("abort_pre_addr_pos", addr_pos_w[0], 32'd4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_sum", sum_w[0], 32'd0);
        check("abort_cycles", cycles_w[0], 32'd0);
        check("abort_busy_done", {30'd0, busy_w[0], done_w[0]}, 32'd0);
        check("abort_re", {30'd0, re_edge_w[0], re_pos_w[0]}, 32'd0);
        check("abort_addr", addr_edge_w[0] | addr_pos_w[0], 32'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done_w[0]) n_done++;
        end
        check("abort_no_done", n_done, 32'd0);
        run_eval(0, 29, 3, 1, 0, "rerun");

        // Second start while busy is ignored.
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        n_done = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (done_w[0]) n_done++;
        end
        check("busy_start_done_count", n_done, 32'd1);
        check("busy_start_sum", sum_w[0], 32'd3);
        check("busy_start_cycles", cycles_w[0], 32'd29);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
